// File: rtl/ghrd_io_pkg.sv
// Shared definitions for the GHRD user I/O conditioner: LED mode codes,
// reset-request kinds and the counter-width helper.
package ghrd_io_pkg;

    localparam logic [1:0] LED_MODE_PIO   = 2'd0;
    localparam logic [1:0] LED_MODE_ON    = 2'd1;
    localparam logic [1:0] LED_MODE_BLINK = 2'd2;
    localparam logic [1:0] LED_MODE_PWM   = 2'd3;

    typedef enum logic [1:0] {RST_NONE, RST_COLD, RST_WARM, RST_DEBUG} rst_kind_e;

    // Bits needed to hold every value 0..max_val without wrapping.
    function automatic int clog2max(input longint max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ghrd_debounce.sv
// Two-flop synchroniser followed by a stability counter; dout only follows
// din once the synchronised value has differed from it for DEBOUNCE_CYC cycles.
module ghrd_debounce
    import ghrd_io_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic dout_next
);

    localparam int CNT_W = clog2max(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout      = db_q;
    assign dout_next = db_d;

endmodule

// File: rtl/ghrd_user_io_ctrl.sv
// Board user I/O conditioner: debounced buttons/switches, per-LED drive modes,
// STM event packing and stretched, prioritised f2h reset requests.
module ghrd_user_io_ctrl
    import ghrd_io_pkg::*;
#(
    parameter int NUM_PB         = 1,
    parameter int NUM_DIPSW      = 2,
    parameter int NUM_LED        = 2,
    parameter int STM_W          = 28,
    parameter int DEBOUNCE_CYC   = 500000,
    parameter int LONG_PRESS_CYC = 150000000,
    parameter int RST_PULSE_CYC  = 16,
    parameter int BLINK_HALF_CYC = 12500000
) (
    input  logic                   sys_clk,
    input  logic                   sys_reset_n,
    input  logic [NUM_PB-1:0]      user_pb_fpga,
    input  logic [NUM_DIPSW-1:0]   user_dipsw_fpga,
    input  logic [NUM_LED-1:0]     led_pio,
    input  logic [2*NUM_LED-1:0]   led_mode,
    input  logic [7:0]             led_duty,
    input  logic [2:0]             issp_reset_req,
    output logic [NUM_PB-1:0]      pb_db,
    output logic [NUM_DIPSW-1:0]   dipsw_db,
    output logic [NUM_PB-1:0]      pb_press,
    output logic [NUM_LED-1:0]     user_led_fpga,
    output logic [STM_W-1:0]       stm_hw_events,
    output logic                   f2h_cold_reset_req_n,
    output logic                   f2h_warm_reset_req_n,
    output logic                   f2h_debug_reset_req_n
);

    localparam int NUM_IN = NUM_PB + NUM_DIPSW;
    localparam int EV_W   = NUM_DIPSW + NUM_LED + NUM_PB;
    localparam int LP_W   = clog2max(LONG_PRESS_CYC);
    localparam int RP_W   = clog2max(RST_PULSE_CYC);
    localparam int BL_W   = clog2max(BLINK_HALF_CYC);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYC);
    localparam logic [LP_W-1:0] LP_FIRE = LP_W'(LONG_PRESS_CYC - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(RST_PULSE_CYC - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HOLDOFF} state_e;

    logic [NUM_IN-1:0] raw_in, db_vec, db_next_vec;

    // Buttons are active-low on the board; invert so that 1 means pressed.
    assign raw_in = {user_dipsw_fpga, ~user_pb_fpga};

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_db
            ghrd_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
                .clk       (sys_clk),
                .rst_n     (sys_reset_n),
                .din       (raw_in[gi]),
                .dout      (db_vec[gi]),
                .dout_next (db_next_vec[gi])
            );
        end
    endgenerate

    assign pb_db    = db_vec[NUM_PB-1:0];
    assign dipsw_db = db_vec[NUM_IN-1:NUM_PB];

    logic [NUM_PB-1:0]  pb_press_q, pb_press_d;
    logic [LP_W-1:0]    lp_cnt_q, lp_cnt_d;
    logic               lp_fire;
    logic [BL_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LED-1:0] led_q, led_d;
    logic [STM_W-1:0]   stm_q, stm_d;
    logic [2:0]         issp_s1_q, issp_s2_q, issp_s3_q;
    logic [2:0]         req_vec, pool, pick_mask;
    rst_kind_e          pick_kind;

    always_comb begin
        pb_press_d = db_next_vec[NUM_PB-1:0] & ~db_vec[NUM_PB-1:0];

        lp_cnt_d = '0;
        if (pb_db[0]) begin
            lp_cnt_d = (lp_cnt_q == LP_MAX) ? lp_cnt_q : lp_cnt_q + 1'b1;
        end
        lp_fire = pb_db[0] && (lp_cnt_q == LP_FIRE);

        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
        if (blink_cnt_q == BL_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
        pwm_cnt_d = pwm_cnt_q + 8'd1;

        led_d = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            case (led_mode[2*i +: 2])
                LED_MODE_PIO:   led_d[i] = led_pio[i];
                LED_MODE_ON:    led_d[i] = 1'b1;
                LED_MODE_BLINK: led_d[i] = blink_q;
                default:        led_d[i] = (pwm_cnt_q < led_duty);
            endcase
        end

        // Built from next-state values so it changes together with the LED/debounce flops.
        stm_d = '0;
        stm_d[EV_W-1:0] = {db_next_vec[NUM_IN-1:NUM_PB], led_d, db_next_vec[NUM_PB-1:0]};
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            pb_press_q  <= '0;
            lp_cnt_q    <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            pwm_cnt_q   <= '0;
            led_q       <= '0;
            stm_q       <= '0;
            issp_s1_q   <= '0;
            issp_s2_q   <= '0;
            issp_s3_q   <= '0;
        end else begin
            pb_press_q  <= pb_press_d;
            lp_cnt_q    <= lp_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            pwm_cnt_q   <= pwm_cnt_d;
            led_q       <= led_d;
            stm_q       <= stm_d;
            issp_s1_q   <= issp_reset_req;
            issp_s2_q   <= issp_s1_q;
            issp_s3_q   <= issp_s2_q;
        end
    end

    assign pb_press      = pb_press_q;
    assign user_led_fpga = led_q;
    assign stm_hw_events = stm_q;

    state_e          state_q;
    logic [RP_W-1:0] rp_cnt_q;
    logic [2:0]      pend_q;
    logic            cold_n_q, warm_n_q, debug_n_q;

    // Bit order {debug, warm, cold}; lowest set bit wins.
    always_comb begin
        req_vec   = {issp_s2_q[2] & ~issp_s3_q[2],
                     (issp_s2_q[1] & ~issp_s3_q[1]) | lp_fire,
                     issp_s2_q[0] & ~issp_s3_q[0]};
        pool      = pend_q | req_vec;
        pick_mask = 3'b000;
        pick_kind = RST_NONE;
        if (pool[0]) begin
            pick_mask = 3'b001;
            pick_kind = RST_COLD;
        end else if (pool[1]) begin
            pick_mask = 3'b010;
            pick_kind = RST_WARM;
        end else if (pool[2]) begin
            pick_mask = 3'b100;
            pick_kind = RST_DEBUG;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q   <= ST_IDLE;
            rp_cnt_q  <= '0;
            pend_q    <= '0;
            cold_n_q  <= 1'b1;
            warm_n_q  <= 1'b1;
            debug_n_q <= 1'b1;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    pend_q <= pool;
                    if (rp_cnt_q == RP_LAST) begin
                        state_q   <= ST_HOLDOFF;
                        rp_cnt_q  <= '0;
                        cold_n_q  <= 1'b1;
                        warm_n_q  <= 1'b1;
                        debug_n_q <= 1'b1;
                    end else begin
                        rp_cnt_q <= rp_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (state_q == ST_HOLDOFF && rp_cnt_q != RP_LAST) begin
                        rp_cnt_q <= rp_cnt_q + 1'b1;
                        pend_q   <= pool;
                    end else if (|pool) begin
                        // End of holdoff chains straight into the next pulse.
                        state_q   <= ST_ASSERT;
                        rp_cnt_q  <= '0;
                        pend_q    <= pool & ~pick_mask;
                        cold_n_q  <= (pick_kind != RST_COLD);
                        warm_n_q  <= (pick_kind != RST_WARM);
                        debug_n_q <= (pick_kind != RST_DEBUG);
                    end else begin
                        state_q  <= ST_IDLE;
                        rp_cnt_q <= '0;
                        pend_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign f2h_cold_reset_req_n  = cold_n_q;
    assign f2h_warm_reset_req_n  = warm_n_q;
    assign f2h_debug_reset_req_n = debug_n_q;

endmodule

// File: tb/tb_ghrd_user_io_ctrl.sv
// Self-checking bench for ghrd_user_io_ctrl with short debounce/press/pulse/blink timings.
module tb_ghrd_user_io_ctrl;

    localparam int DB = 8;
    localparam int LP = 64;
    localparam int RP = 4;
    localparam int BH = 5;

    logic        sys_clk = 1'b0;
    logic        sys_reset_n = 1'b1;
    logic [0:0]  user_pb_fpga;
    logic [1:0]  user_dipsw_fpga;
    logic [1:0]  led_pio;
    logic [3:0]  led_mode;
    logic [7:0]  led_duty;
    logic [2:0]  issp_reset_req;
    logic [0:0]  pb_db;
    logic [1:0]  dipsw_db;
    logic [0:0]  pb_press;
    logic [1:0]  user_led_fpga;
    logic [27:0] stm_hw_events;
    logic        cold_n, warm_n, debug_n;

    int checks = 0;
    int errors = 0;

    ghrd_user_io_ctrl #(
        .NUM_PB(1), .NUM_DIPSW(2), .NUM_LED(2), .STM_W(28),
        .DEBOUNCE_CYC(DB), .LONG_PRESS_CYC(LP), .RST_PULSE_CYC(RP), .BLINK_HALF_CYC(BH)
    ) dut (
        .sys_clk               (sys_clk),
        .sys_reset_n           (sys_reset_n),
        .user_pb_fpga          (user_pb_fpga),
        .user_dipsw_fpga       (user_dipsw_fpga),
        .led_pio               (led_pio),
        .led_mode              (led_mode),
        .led_duty              (led_duty),
        .issp_reset_req        (issp_reset_req),
        .pb_db                 (pb_db),
        .dipsw_db              (dipsw_db),
        .pb_press              (pb_press),
        .user_led_fpga         (user_led_fpga),
        .stm_hw_events         (stm_hw_events),
        .f2h_cold_reset_req_n  (cold_n),
        .f2h_warm_reset_req_n  (warm_n),
        .f2h_debug_reset_req_n (debug_n)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        user_pb_fpga    = 1'b1;
        user_dipsw_fpga = 2'b00;
        led_pio         = 2'b00;
        led_mode        = 4'b0000;
        led_duty        = 8'd0;
        issp_reset_req  = 3'b000;
    endtask

    task automatic apply_reset();
        idle_inputs();
        sys_reset_n = 1'b0;
        repeat (3) tick();
        sys_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        led_mode = 4'b0101;
        #2 sys_reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (pb_db !== 1'b0) begin errors++; $display("FAIL reset_pb_db: got %0h expected 0", pb_db); end
        checks++; if (dipsw_db !== 2'b00) begin errors++; $display("FAIL reset_dipsw_db: got %0h expected 0", dipsw_db); end
        checks++; if (pb_press !== 1'b0) begin errors++; $display("FAIL reset_pb_press: got %0h expected 0", pb_press); end
        checks++; if (user_led_fpga !== 2'b00) begin errors++; $display("FAIL reset_led: got %0h expected 0", user_led_fpga); end
        checks++; if (stm_hw_events !== 28'h0) begin errors++; $display("FAIL reset_stm: got %0h expected 0", stm_hw_events); end
        checks++; if ({cold_n, warm_n, debug_n} !== 3'b111) begin errors++; $display("FAIL reset_req_n: got %0b expected 111", {cold_n, warm_n, debug_n}); end
        idle_inputs();
        sys_reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_glitch();
        int seen, first, presses;
        seen = 0;
        user_pb_fpga = 1'b0;
        repeat (5) begin tick(); if (pb_db) seen++; end
        user_pb_fpga = 1'b1;
        repeat (20) begin tick(); if (pb_db) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL glitch_reject: got %0d high cycles expected 0", seen); end

        first = -1; presses = 0;
        user_pb_fpga = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (pb_db === 1'b1 && first < 0) first = k;
            if (pb_press === 1'b1) presses++;
        end
        checks++; if (first != DB + 2) begin errors++; $display("FAIL press_latency: got %0d expected %0d", first, DB + 2); end
        user_pb_fpga = 1'b1;
        repeat (15) begin tick(); if (pb_press === 1'b1) presses++; end
        checks++; if (presses != 1) begin errors++; $display("FAIL press_pulse_count: got %0d expected 1", presses); end
        checks++; if (pb_db !== 1'b0) begin errors++; $display("FAIL release_pb_db: got %0h expected 0", pb_db); end
    endtask

    // Reference: a debounced bit flips once its last DB synchronised samples
    // (raw delayed by two cycles) all disagree with it.
    task automatic test_random_dipsw();
        logic [1:0] hist[$];
        logic [1:0] m_db, raw;
        int         hold;
        bit         all_diff;
        apply_reset();
        hist = {};
        repeat (DB + 2) hist.push_back(2'b00);
        m_db = 2'b00; raw = 2'b00; hold = 0;
        for (int t = 0; t < 300; t++) begin
            if (hold == 0) begin
                raw  = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 14);
            end
            hold--;
            user_dipsw_fpga = raw;
            tick();
            hist.push_back(raw);
            for (int b = 0; b < 2; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    if (hist[hist.size() - 3 - j][b] == m_db[b]) all_diff = 1'b0;
                end
                if (all_diff) m_db[b] = ~m_db[b];
            end
            checks++; if (dipsw_db !== m_db) begin errors++; $display("FAIL rand_dipsw t=%0d: got %0b expected %0b", t, dipsw_db, m_db); end
            checks++; if (stm_hw_events !== (28'(m_db) << 3)) begin errors++; $display("FAIL rand_stm t=%0d: got %0h expected %0h", t, stm_hw_events, 28'(m_db) << 3); end
        end
        user_dipsw_fpga = 2'b00;
        repeat (DB + 4) tick();
    endtask

    task automatic test_long_press();
        int lows, falls, other, presses;
        logic prev;
        for (int r = 0; r < 2; r++) begin
            lows = 0; falls = 0; other = 0; presses = 0; prev = 1'b1;
            user_pb_fpga = 1'b0;
            for (int k = 0; k < 140; k++) begin
                if (k == 100) user_pb_fpga = 1'b1;
                tick();
                if (warm_n === 1'b0) lows++;
                if (prev === 1'b1 && warm_n === 1'b0) falls++;
                prev = warm_n;
                if (cold_n !== 1'b1 || debug_n !== 1'b1) other++;
                if (pb_press === 1'b1) presses++;
            end
            checks++; if (lows != RP) begin errors++; $display("FAIL long_press_len r=%0d: got %0d expected %0d", r, lows, RP); end
            checks++; if (falls != 1) begin errors++; $display("FAIL long_press_count r=%0d: got %0d expected 1", r, falls); end
            checks++; if (other != 0) begin errors++; $display("FAIL long_press_other r=%0d: got %0d expected 0", r, other); end
            checks++; if (presses != 1) begin errors++; $display("FAIL long_press_pb_press r=%0d: got %0d expected 1", r, presses); end
        end
    endtask

    task automatic test_priority();
        logic [2:0] trace [40];
        logic [2:0] exp_v;
        int         start, o;
        start = -1;
        issp_reset_req = 3'b011;
        for (int k = 0; k < 40; k++) begin
            tick();
            trace[k] = {cold_n, warm_n, debug_n};
            if (start < 0 && cold_n === 1'b0) start = k;
        end
        issp_reset_req = 3'b000;
        checks++;
        if (start < 0 || start > 10) begin
            errors++; $display("FAIL priority_start: got %0d expected 0..10", start);
        end else begin
            for (int k = 0; k < 40; k++) begin
                o = k - start;
                exp_v = {!(o >= 0 && o < RP), !(o >= 2 * RP && o < 3 * RP), 1'b1};
                checks++;
                if (trace[k] !== exp_v) begin errors++; $display("FAIL priority_trace k=%0d: got %0b expected %0b", k, trace[k], exp_v); end
            end
        end
        repeat (5) tick();
    endtask

    task automatic test_reset_mid_pulse();
        int found, lows;
        found = 0; lows = 0;
        issp_reset_req = 3'b011;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick();
            if (cold_n === 1'b0) found = 1;
        end
        checks++; if (found == 0) begin errors++; $display("FAIL midrst_wait: got no cold pulse expected one"); end
        tick();
        sys_reset_n = 1'b0;
        #1;
        checks++; if ({cold_n, warm_n, debug_n} !== 3'b111) begin errors++; $display("FAIL midrst_async: got %0b expected 111", {cold_n, warm_n, debug_n}); end
        tick();
        checks++; if ({cold_n, warm_n, debug_n} !== 3'b111) begin errors++; $display("FAIL midrst_edge: got %0b expected 111", {cold_n, warm_n, debug_n}); end
        issp_reset_req = 3'b000;
        tick();
        sys_reset_n = 1'b1;
        repeat (40) begin
            tick();
            if ({cold_n, warm_n, debug_n} !== 3'b111) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL midrst_no_pending: got %0d asserted cycles expected 0", lows); end
    endtask

    task automatic test_led();
        logic   prev;
        int     last, trans, high;
        int     duties [5];
        led_mode = {2'd3, 2'd2};
        led_duty = 8'd64;
        repeat (2) tick();
        prev = user_led_fpga[0]; last = -1; trans = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (user_led_fpga[0] !== prev) begin
                if (last >= 0) begin
                    checks++;
                    if (k - last != BH) begin errors++; $display("FAIL blink_period: got %0d expected %0d", k - last, BH); end
                end
                last = k; trans++;
                prev = user_led_fpga[0];
            end
        end
        checks++; if (trans < 10) begin errors++; $display("FAIL blink_toggles: got %0d expected >=10", trans); end

        duties[0] = 64; duties[1] = 0; duties[2] = 255;
        duties[3] = $urandom_range(1, 254); duties[4] = $urandom_range(1, 254);
        for (int d = 0; d < 5; d++) begin
            led_duty = 8'(duties[d]);
            repeat (2) tick();
            high = 0;
            repeat (256) begin tick(); if (user_led_fpga[1] === 1'b1) high++; end
            checks++; if (high != duties[d]) begin errors++; $display("FAIL pwm_duty d=%0d: got %0d expected %0d", duties[d], high, duties[d]); end
        end

        led_mode = 4'b0000;
        led_pio  = 2'b10;
        tick();
        checks++; if (user_led_fpga !== 2'b10) begin errors++; $display("FAIL led_pio_mode: got %0b expected 10", user_led_fpga); end
        led_mode = 4'b0101;
        tick();
        checks++; if (user_led_fpga !== 2'b11) begin errors++; $display("FAIL led_on_mode: got %0b expected 11", user_led_fpga); end
    endtask

    task automatic test_stm();
        logic [27:0] upper;
        led_mode        = 4'b0000;
        led_pio         = 2'b10;
        user_dipsw_fpga = 2'b01;
        user_pb_fpga    = 1'b0;
        repeat (DB + 4) tick();
        checks++; if (stm_hw_events !== 28'h000000D) begin errors++; $display("FAIL stm_pack: got %0h expected D", stm_hw_events); end
        upper = stm_hw_events >> 5;
        checks++; if (upper !== 28'h0) begin errors++; $display("FAIL stm_pad: got %0h expected 0", upper); end
        led_pio = 2'b01;
        tick();
        checks++; if ({user_led_fpga, stm_hw_events} !== {2'b01, 28'h000000B}) begin
            errors++; $display("FAIL stm_same_cycle: got led %0b stm %0h expected led 01 stm B", user_led_fpga, stm_hw_events);
        end
        user_pb_fpga = 1'b1;
        repeat (DB + 4) tick();
        checks++; if (stm_hw_events !== 28'h000000A) begin errors++; $display("FAIL stm_release: got %0h expected A", stm_hw_events); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_glitch();
        test_random_dipsw();
        test_long_press();
        test_priority();
        test_reset_mid_pulse();
        test_led();
        test_stm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
